uart_rx: RTL and testbench

- Serial receiver for the SOC UART link: the far-end counterpart of the SOC's TXD transmitter; used in benches and as the SOC's RXD input stage.
- Samples an asynchronous 8N1 line at mid-bit and delivers bytes through a level-valid/ack interface.
- Reports framing and overrun errors.

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, level valid/ack output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic              rxd_meta_q, rxd_s_q;
  logic              rxd_prev_q, rxd_prev_d;
  logic [1:0]        settle_q, settle_d;
  logic [CntW-1:0]   cyc_q, cyc_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              fall;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_prev_q  <= 1'b0;
      settle_q    <= 2'b00;
      state_q     <= StIdle;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= i_rxd;
      rxd_s_q     <= rxd_meta_q;
      rxd_prev_q  <= rxd_prev_d;
      settle_q    <= settle_d;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // The synchronizer holds its reset value of 1 for two cycles after release; keep the
  // edge history at 0 until real line samples arrive so a low line cannot fake a start.
  assign settle_d   = {settle_q[0], 1'b1};
  assign rxd_prev_d = rxd_s_q & settle_q[1];
  assign fall       = rxd_prev_q & ~rxd_s_q;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~i_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cyc_q == HalfLast) begin
          cyc_d   = '0;
          state_d = rxd_s_q ? StIdle : StData;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      StData: begin
        if (cyc_q == BitLast) begin
          cyc_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cyc_q == BitLast) begin
          cyc_d     = '0;
          par_bad_d = rxd_s_q ^ (^shift_q);
          state_d   = StStop;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (cyc_q == BitLast) begin
          cyc_d   = '0;
          state_d = StIdle;
          if (!rxd_s_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            // A same-cycle ack consumes the old byte, so the new one is not an overrun.
            data_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~i_ack;
          end
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q != StIdle);
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; define UART_RX_PARITY_EN to
// also exercise the parity build.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int Lat = 108;
`else
  localparam int Lat = 98;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_frame_err, o_overrun, o_parity_err;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   fall_cyc = 0;
  int   rise_cyc = 0;
  int   n_ferr = 0, n_ovr = 0, n_perr = 0, n_busy = 0;
  logic valid_d1 = 1'b0;
  logic last_par = 1'b0;
  int   s_ferr, s_ovr, s_perr, s_busy, lat;

  uart_rx #(
    .CLK_FREQ_HZ(1000000),
    .BAUD_RATE  (100000)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rxd       (rxd),
    .i_ack       (ack),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_parity_err(o_parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    valid_d1 <= o_valid;
    if (o_valid && !valid_d1) rise_cyc <= cyc;
    n_ferr <= n_ferr + int'(o_frame_err);
    n_ovr  <= n_ovr + int'(o_overrun);
    n_perr <= n_perr + int'(o_parity_err);
    n_busy <= n_busy + int'(o_busy);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par);
    last_par = par;
    rxd      = 1'b0;
    fall_cyc = cyc;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(10);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    tick(10);
`endif
    rxd = stop_bit;
    tick(10);
    rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic snap();
    s_ferr = n_ferr;
    s_ovr  = n_ovr;
    s_perr = n_perr;
    s_busy = n_busy;
  endtask

  initial begin
    tick(3);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    tick(2);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_ovr", 32'(o_overrun), 32'd0);
    check("rst_perr", 32'(o_parity_err), 32'd0);

    // Plain frame 0xA5
    snap();
    send(8'hA5);
    tick(3);
    lat = rise_cyc - fall_cyc;
    check("a5_valid", 32'(o_valid), 32'd1);
    check("a5_data", 32'(o_data), 32'hA5);
    check("a5_latency", 32'(lat >= Lat - 1 && lat <= Lat + 1), 32'd1);
    check("a5_busy_cycles", 32'(n_busy - s_busy >= Lat - 8 && n_busy - s_busy <= Lat + 2), 32'd1);
    check("a5_busy_end", 32'(o_busy), 32'd0);
    check("a5_no_ferr", 32'(n_ferr - s_ferr), 32'd0);
    check("a5_no_ovr", 32'(n_ovr - s_ovr), 32'd0);
    check("a5_no_perr", 32'(n_perr - s_perr), 32'd0);
    ack_pulse();
    check("a5_ack_clears", 32'(o_valid), 32'd0);
    ack_pulse();
    check("idle_ack_ignored", 32'(o_valid), 32'd0);

    // 3-cycle glitch is rejected by the start check
    tick(10);
    snap();
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(8);
    check("glitch_saw_start", 32'(n_busy - s_busy > 0), 32'd1);
    check("glitch_busy", 32'(o_busy), 32'd0);
    check("glitch_valid", 32'(o_valid), 32'd0);
    check("glitch_ferr", 32'(n_ferr - s_ferr), 32'd0);

    // Framing error, then a clean frame
    tick(10);
    snap();
    send_frame(8'h3C, 1'b0, ^8'h3C);
    tick(20);
    check("ferr_pulse", 32'(n_ferr - s_ferr), 32'd1);
    check("ferr_valid", 32'(o_valid), 32'd0);
    check("ferr_data_kept", 32'(o_data), 32'hA5);
    check("ferr_no_perr", 32'(n_perr - s_perr), 32'd0);
    send(8'h55);
    tick(3);
    check("after_ferr_valid", 32'(o_valid), 32'd1);
    check("after_ferr_data", 32'(o_data), 32'h55);
    check("after_ferr_count", 32'(n_ferr - s_ferr), 32'd1);
    ack_pulse();

    // Back-to-back overrun
    tick(10);
    snap();
    send(8'h11);
    send(8'h22);
    tick(3);
    check("ovr_data", 32'(o_data), 32'h22);
    check("ovr_valid", 32'(o_valid), 32'd1);
    check("ovr_pulse", 32'(n_ovr - s_ovr), 32'd1);
    ack_pulse();

    // Ack in the completion cycle: new byte wins, no overrun
    tick(10);
    snap();
    send(8'h11);
    fork
      send(8'h22);
      begin
        tick(Lat - 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end
    join
    tick(3);
    check("ackc_data", 32'(o_data), 32'h22);
    check("ackc_valid", 32'(o_valid), 32'd1);
    check("ackc_no_ovr", 32'(n_ovr - s_ovr), 32'd0);
    // o_valid left pending so the reset below has something to clear

    // Reset at bit 4 of 0xFF, line held low afterwards
    tick(10);
    rxd = 1'b0;
    tick(10);
    rxd = 1'b1;
    tick(43);
    rst = 1'b1;
    rxd = 1'b0;
    tick(2);
    check("midrst_valid", 32'(o_valid), 32'd0);
    rst = 1'b0;
    snap();
    tick(40);
    check("midrst_no_start", 32'(n_busy - s_busy), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_valid_after", 32'(o_valid), 32'd0);
    check("midrst_data", 32'(o_data), 32'h00);
    check("midrst_no_ferr", 32'(n_ferr - s_ferr), 32'd0);
    rxd = 1'b1;
    tick(20);
    send(8'h81);
    tick(3);
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_data", 32'(o_data), 32'h81);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    tick(10);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    tick(3);
    check("par_ok_valid", 32'(o_valid), 32'd1);
    check("par_ok_data", 32'(o_data), 32'h07);
    check("par_ok_no_perr", 32'(n_perr - s_perr), 32'd0);
    ack_pulse();
    tick(10);
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    tick(3);
    check("par_bad_pulse", 32'(n_perr - s_perr), 32'd1);
    check("par_bad_valid", 32'(o_valid), 32'd0);
    check("par_bad_no_ferr", 32'(n_ferr - s_ferr), 32'd0);
`endif

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
